// File: rtl/compare_unit_seq_pkg.sv
// Shared encodings for the sequential compare/select unit: op codes (same as the
// ALU decoder), FSM states, and a helper that classifies signed ops.
package compare_unit_seq_pkg;

  localparam logic [2:0] OP_SLT  = 3'b000;
  localparam logic [2:0] OP_SLTU = 3'b001;
  localparam logic [2:0] OP_SEQ  = 3'b010;
  localparam logic [2:0] OP_SNE  = 3'b011;
  localparam logic [2:0] OP_SGE  = 3'b100;
  localparam logic [2:0] OP_SGEU = 3'b101;
  localparam logic [2:0] OP_MINS = 3'b110;
  localparam logic [2:0] OP_MAXS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_SLT) || (op == OP_SGE) || (op == OP_MINS) || (op == OP_MAXS);
  endfunction

endpackage

// File: rtl/compare_unit_seq_chunk.sv
// Combinational unsigned compare of one CHUNK-wide slice of the operands.
module compare_unit_seq_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  output logic             lt,
  output logic             eq
);

  assign lt = (ca < cb);
  assign eq = (ca == cb);

endmodule

// File: rtl/compare_unit_seq.sv
// Multi-cycle compare/select unit: scans operands MSB-first, CHUNK bits per cycle,
// with valid/ready handshakes on both sides and registered outputs.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | waiting for in_valid; in_ready high
//  ST_SCAN | comparing chunk idx, idx counting down from NCH-1 to 0
//  ST_DONE | result held with out_valid high until out_ready
module compare_unit_seq
  import compare_unit_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("compare_unit_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  cmp_state_e state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] ca_r, cb_r;
  logic             lt_r, eq_r;
  logic             sgn_in;

  logic [CHUNK-1:0] ca_sel, cb_sel;
  logic             chunk_lt, chunk_eq;
  logic             first_diff, scan_last;
  logic             lt_fin, eq_fin;
  logic [WIDTH-1:0] res_nxt;

  assign ca_sel = ca_r[idx*CHUNK +: CHUNK];
  assign cb_sel = cb_r[idx*CHUNK +: CHUNK];

  compare_unit_seq_chunk #(.CHUNK(CHUNK)) u_chunk (
    .ca (ca_sel),
    .cb (cb_sel),
    .lt (chunk_lt),
    .eq (chunk_eq)
  );

  // eq_r stays 1 until the first differing chunk; only that chunk sets the order.
  assign first_diff = eq_r & ~chunk_eq;
  assign lt_fin     = first_diff ? chunk_lt : lt_r;
  assign eq_fin     = eq_r & chunk_eq;
  assign scan_last  = (EARLY_EXIT && !chunk_eq) || (idx == '0);
  assign sgn_in     = is_signed_op(op);

  always_comb begin
    res_nxt = '0;
    case (op_r)
      OP_SLT, OP_SLTU: res_nxt[0] = lt_fin;
      OP_SGE, OP_SGEU: res_nxt[0] = ~lt_fin;
      OP_SEQ:          res_nxt[0] = eq_fin;
      OP_SNE:          res_nxt[0] = ~eq_fin;
      OP_MINS:         res_nxt    = lt_fin ? a_r : b_r;
      OP_MAXS:         res_nxt    = lt_fin ? b_r : a_r;
      default:         res_nxt    = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_SCAN;
      ST_SCAN: if (scan_last) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      ca_r   <= '0;
      cb_r   <= '0;
      lt_r   <= 1'b0;
      eq_r   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
            // Flipping both MSBs turns two's-complement order into unsigned order.
            ca_r <= {a[WIDTH-1] ^ sgn_in, a[WIDTH-2:0]};
            cb_r <= {b[WIDTH-1] ^ sgn_in, b[WIDTH-2:0]};
            idx  <= IDX_W'(NCH - 1);
            lt_r <= 1'b0;
            eq_r <= 1'b1;
          end
        end
        ST_SCAN: begin
          lt_r <= lt_fin;
          eq_r <= eq_fin;
          if (idx != '0) idx <= idx - 1'b1;
          if (scan_last) result <= res_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_compare_unit_seq.sv
// Bench for compare_unit_seq: a 32/8 early-exit instance and a 16/4 full-scan instance,
// checked against an arithmetic reference model of results and latency.
module tb_compare_unit_seq;

  localparam logic [2:0] SLT = 3'd0, SLTU = 3'd1, SEQ = 3'd2, SNE = 3'd3;
  localparam logic [2:0] SGE = 3'd4, SGEU = 3'd5, MINS = 3'd6, MAXS = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        iv32 = 0, ir32, ov32, or32 = 0, busy32;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, res32;

  logic        iv16 = 0, ir16, ov16, or16 = 0, busy16;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, res16;

  compare_unit_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(res32), .busy(busy32)
  );

  compare_unit_seq #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .result(res16), .busy(busy16)
  );

  // Reference result for a w-bit operation on zero-extended operands.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, y, input int w);
    longint ux, uy, sx, sy;
    logic lts, ltu;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[w-1] ? ux - (longint'(1) << w) : ux;
    sy = y[w-1] ? uy - (longint'(1) << w) : uy;
    lts = (sx < sy);
    ltu = (ux < uy);
    case (o)
      SLT:     return {31'd0, lts};
      SLTU:    return {31'd0, ltu};
      SEQ:     return {31'd0, ux == uy};
      SNE:     return {31'd0, ux != uy};
      SGE:     return {31'd0, !lts};
      SGEU:    return {31'd0, !ltu};
      MINS:    return lts ? x : y;
      default: return lts ? y : x;
    endcase
  endfunction

  function automatic int lat_model(input logic [31:0] x, y, input int w, ch, input bit ee);
    int nch;
    logic [31:0] d;
    nch = w / ch;
    if (!ee) return nch;
    d = x ^ y;
    for (int i = nch - 1; i >= 0; i--)
      if (((d >> (i * ch)) & ((32'd1 << ch) - 1)) != 0) return nch - i;
    return nch;
  endfunction

  function automatic logic [31:0] pick_b(input logic [31:0] x, input int w);
    logic [31:0] y;
    case ($urandom_range(0, 3))
      0:       y = x;
      1:       y = x ^ (32'd1 << $urandom_range(0, w - 1));
      2:       y = x ^ (32'd1 << $urandom_range(0, 3));
      default: y = $urandom;
    endcase
    return y;
  endfunction

  task automatic run32(input logic [2:0] o, input logic [31:0] x, y,
                       output logic [31:0] res, output int lat);
    int n;
    iv32 = 1; op32 = o; a32 = x; b32 = y;
    n = 0;
    while (!ir32 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!ir32) begin failures++; $display("FAIL handshake32 in_ready=%0b required=1", ir32); end
    @(posedge clk); #1; iv32 = 0;
    lat = 0;
    while (!ov32 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = res32;
    or32 = 1; @(posedge clk); #1; or32 = 0;
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] x, y,
                       output logic [15:0] res, output int lat);
    int n;
    iv16 = 1; op16 = o; a16 = x; b16 = y;
    n = 0;
    while (!ir16 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!ir16) begin failures++; $display("FAIL handshake16 in_ready=%0b required=1", ir16); end
    @(posedge clk); #1; iv16 = 0;
    lat = 0;
    while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
    res = res16;
    or16 = 1; @(posedge clk); #1; or16 = 0;
  endtask

  task automatic check32(input string name, input logic [2:0] o, input logic [31:0] x, y,
                         input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] r;
    int l;
    run32(o, x, y, r, l);
    checks++;
    if (r !== exp_res) begin failures++; $display("FAIL %s result=%h required=%h", name, r, exp_res); end
    checks++;
    if (l != exp_lat) begin failures++; $display("FAIL %s latency=%0d required=%0d", name, l, exp_lat); end
  endtask

  task automatic test_reset();
    checks++;
    if ({ir32, ov32, busy32} !== 3'b100 || res32 !== 32'd0) begin
      failures++;
      $display("FAIL reset32 ir/ov/busy=%b result=%h required=100/00000000", {ir32, ov32, busy32}, res32);
    end
    checks++;
    if ({ir16, ov16, busy16} !== 3'b100 || res16 !== 16'd0) begin
      failures++;
      $display("FAIL reset16 ir/ov/busy=%b result=%h required=100/0000", {ir16, ov16, busy16}, res16);
    end
  endtask

  task automatic test_vectors();
    check32("slt_neg",   SLT,  32'hFFFFFFFF, 32'h00000001, 32'h1, 1);
    check32("sltu_big",  SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1);
    check32("seq_eq",    SEQ,  32'h12345678, 32'h12345678, 32'h1, 4);
    check32("sne_eq",    SNE,  32'h12345678, 32'h12345678, 32'h0, 4);
    check32("sltu_low",  SLTU, 32'h12345600, 32'h12345601, 32'h1, 4);
    check32("mins",      MINS, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1);
    check32("maxs",      MAXS, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
    check32("maxs_tie",  MAXS, 32'h00000005, 32'h00000005, 32'h00000005, 4);
    check32("sge_mid",   SGE,  32'h00120000, 32'h00130000, 32'h0, 2);
    check32("sgeu_mid",  SGEU, 32'h00001300, 32'h00001200, 32'h1, 3);
  endtask

  task automatic test_backpressure();
    logic [31:0] r0;
    int l, bad;
    iv32 = 1; op32 = SLTU; a32 = 32'h10; b32 = 32'h20;
    @(posedge clk); #1;
    iv32 = 1; op32 = SEQ; a32 = 32'h7; b32 = 32'h7;
    l = 0;
    while (!ov32 && l < 50) begin @(posedge clk); #1; l++; end
    r0 = res32;
    checks++;
    if (r0 !== 32'h1 || l != 4) begin failures++; $display("FAIL bp_first result=%h lat=%0d required=00000001/4", r0, l); end
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b1 || res32 !== r0 || ir32 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold unstable_cycles=%0d required=0", bad); end
    or32 = 1; @(posedge clk); #1; or32 = 0;
    checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin failures++; $display("FAIL bp_release ov=%b ir=%b required=0/1", ov32, ir32); end
    @(posedge clk); #1; iv32 = 0;
    l = 0;
    while (!ov32 && l < 50) begin @(posedge clk); #1; l++; end
    checks++;
    if (res32 !== 32'h1 || l != 4) begin failures++; $display("FAIL bp_second result=%h lat=%0d required=00000001/4", res32, l); end
    or32 = 1; @(posedge clk); #1; or32 = 0;
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    iv32 = 1; op32 = SEQ; a32 = 32'h12345678; b32 = 32'h12345678;
    @(posedge clk); #1; iv32 = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checks++;
    if ({ir32, ov32, busy32} !== 3'b100 || res32 !== 32'd0) begin
      failures++;
      $display("FAIL midscan_reset ir/ov/busy=%b result=%h required=100/00000000", {ir32, ov32, busy32}, res32);
    end
    @(posedge clk); @(posedge clk); #1; rst_n = 1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (ov32 !== 1'b0 || ir32 !== 1'b1) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midscan_abort bad_cycles=%0d required=0", seen); end
    check32("after_reset", SLT, 32'hFFFFFFFF, 32'h00000001, 32'h1, 1);
  endtask

  task automatic test_random32();
    logic [31:0] x, y, r, e;
    logic [2:0] o;
    int l, el;
    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = pick_b(x, 32); o = 3'($urandom_range(0, 7));
      e = model(o, x, y, 32); el = lat_model(x, y, 32, 8, 1'b1);
      run32(o, x, y, r, l);
      checks++;
      if (r !== e || l != el) begin
        failures++;
        $display("FAIL rand32 op=%0d a=%h b=%h result=%h lat=%0d required=%h/%0d", o, x, y, r, l, e, el);
      end
    end
  endtask

  task automatic test_width16_full_scan();
    logic [15:0] x, y, r;
    logic [31:0] e;
    logic [2:0] o;
    int l;
    run16(SGE, 16'h8000, 16'h0001, r, l);
    checks++;
    if (r !== 16'h0000 || l != 4) begin failures++; $display("FAIL w16_sge result=%h lat=%0d required=0000/4", r, l); end
    for (int i = 0; i < 30; i++) begin
      x = 16'($urandom); y = 16'(pick_b({16'd0, x}, 16)); o = 3'($urandom_range(0, 7));
      e = model(o, {16'd0, x}, {16'd0, y}, 16);
      run16(o, x, y, r, l);
      checks++;
      if (r !== e[15:0] || l != 4) begin
        failures++;
        $display("FAIL rand16 op=%0d a=%h b=%h result=%h lat=%0d required=%h/4", o, x, y, r, l, e[15:0]);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    @(posedge clk); #1;
    test_vectors();
    test_backpressure();
    test_reset_mid_scan();
    test_random32();
    test_width16_full_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
